// File: rtl/id_ex_reg_pkg.sv
// id_ex_reg_pkg: shared types and constants for the ID/EX stage.
//   - ALU operation codes driven on id_alu_op / ex_alu_op
//   - REG_X0, the hard-wired zero register index
//   - id_ex_t, the contents of the ID/EX register, and BUBBLE, its
//     "no instruction" value (valid, rf_we, ram_we, is_load all 0)
//   - fwd_sel_e, operand source select produced by hazard_unit
//   - reg_match(), the producer/consumer match rule shared by all checks
package id_ex_reg_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1011;

    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  imm;
        logic [3:0]       alu_op;
        logic             alub_sel;
        logic             rf_we;
        logic             ram_we;
        logic             is_load;
    } id_ex_t;

    // A bubble kills every side effect; the data fields are zeroed too so
    // that a bubble is a single well-defined value.
    localparam id_ex_t BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_e;

    // A producer feeds a source only if it writes, is not x0, and names it.
    function automatic logic reg_match(input logic we,
                                       input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs);
        return we && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_reg_hazard_unit.sv
// hazard_unit: combinational hazard detection and forward selection.
//   in : ID sources (id_valid, id_rs1, id_rs2), the EX instruction held in
//        the ID/EX register, the EX/MEM and MEM/WB producers
//   out: hazard   - ID instruction must wait (stall is derived in the top)
//        wb_byp1/2 - latch mwb_wd instead of the register-file read
//        fwd1/2_sel - source of ex_rD1/ex_rD2
// Macro ID_EX_FORWARD_EN: with it, only load-use stalls and all bypasses
// are active; without it, any in-flight producer stalls the consumer until
// it has retired and the operands always come from the register file.
module hazard_unit
    import id_ex_reg_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] exm_rd,
    input  logic             exm_rf_we,
    input  logic             exm_is_load,
    input  logic [REG_W-1:0] mwb_rd,
    input  logic             mwb_rf_we,
    output logic             hazard,
    output logic             wb_byp1,
    output logic             wb_byp2,
    output fwd_sel_e         fwd1_sel,
    output fwd_sel_e         fwd2_sel
);

`ifdef ID_EX_FORWARD_EN
    // Load data is not ready in EX/MEM, so a load there must not forward;
    // the consumer was held one cycle and picks it up from MEM/WB instead.
    function automatic fwd_sel_e pick(input logic [REG_W-1:0] rs);
        if (reg_match(exm_rf_we, exm_rd, rs) && !exm_is_load) return FWD_EXM;
        if (reg_match(mwb_rf_we, mwb_rd, rs))                 return FWD_MWB;
        return FWD_REG;
    endfunction

    assign hazard   = id_valid && ex_valid && ex_is_load &&
                      (reg_match(ex_rf_we, ex_rd, id_rs1) ||
                       reg_match(ex_rf_we, ex_rd, id_rs2));
    // Register file has no write-through, so a same-cycle WB write is
    // picked up here on capture.
    assign wb_byp1  = reg_match(mwb_rf_we, mwb_rd, id_rs1);
    assign wb_byp2  = reg_match(mwb_rf_we, mwb_rd, id_rs2);
    assign fwd1_sel = pick(ex_rs1);
    assign fwd2_sel = pick(ex_rs2);
`else
    logic unused_fwd;

    assign hazard   = id_valid &&
                      ((ex_valid && (reg_match(ex_rf_we, ex_rd, id_rs1) ||
                                     reg_match(ex_rf_we, ex_rd, id_rs2))) ||
                       reg_match(exm_rf_we, exm_rd, id_rs1) ||
                       reg_match(exm_rf_we, exm_rd, id_rs2) ||
                       reg_match(mwb_rf_we, mwb_rd, id_rs1) ||
                       reg_match(mwb_rf_we, mwb_rd, id_rs2));
    assign wb_byp1  = 1'b0;
    assign wb_byp2  = 1'b0;
    assign fwd1_sel = FWD_REG;
    assign fwd2_sel = FWD_REG;
    assign unused_fwd = ^{ex_is_load, ex_rs1, ex_rs2, exm_is_load};
`endif

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register of the 5-stage RV32I core.
//   in : clk, rst_n (async, active low), flush, id_* decoded instruction,
//        exm_* EX/MEM producer, mwb_* MEM/WB producer
//   out: stall (hold PC and IF/ID), ex_* registered instruction,
//        ex_rD1/ex_rD2 operands after forwarding
// Edge priority: flush > hazard > capture; both flush and hazard load a
// bubble. stall is suppressed under flush since the ID instruction is dead.
// Macro ID_EX_FORWARD_EN enables forwarding (see hazard_unit).
module id_ex_reg
    import id_ex_reg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic [XLEN-1:0]  id_rD1,
    input  logic [XLEN-1:0]  id_rD2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alub_sel,
    input  logic             id_rf_we,
    input  logic             id_ram_we,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] exm_rd,
    input  logic             exm_rf_we,
    input  logic             exm_is_load,
    input  logic [XLEN-1:0]  exm_wd,
    input  logic [REG_W-1:0] mwb_rd,
    input  logic             mwb_rf_we,
    input  logic [XLEN-1:0]  mwb_wd,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_alub_sel,
    output logic             ex_rf_we,
    output logic             ex_ram_we,
    output logic             ex_is_load,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REG_W-1:0] ex_rd,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rs2,
    output logic [3:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_rD1,
    output logic [XLEN-1:0]  ex_rD2
);

    id_ex_t   ex_q;
    id_ex_t   id_d;
    logic     hazard;
    logic     wb_byp1, wb_byp2;
    fwd_sel_e fwd1_sel, fwd2_sel;

    hazard_unit u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (ex_q.valid),
        .ex_rd       (ex_q.rd),
        .ex_rf_we    (ex_q.rf_we),
        .ex_is_load  (ex_q.is_load),
        .ex_rs1      (ex_q.rs1),
        .ex_rs2      (ex_q.rs2),
        .exm_rd      (exm_rd),
        .exm_rf_we   (exm_rf_we),
        .exm_is_load (exm_is_load),
        .mwb_rd      (mwb_rd),
        .mwb_rf_we   (mwb_rf_we),
        .hazard      (hazard),
        .wb_byp1     (wb_byp1),
        .wb_byp2     (wb_byp2),
        .fwd1_sel    (fwd1_sel),
        .fwd2_sel    (fwd2_sel)
    );

    assign stall = hazard && !flush;

    always_comb begin
        id_d          = BUBBLE;
        id_d.valid    = id_valid;
        id_d.pc       = id_pc;
        id_d.rd       = id_rd;
        id_d.rs1      = id_rs1;
        id_d.rs2      = id_rs2;
        id_d.rd1      = wb_byp1 ? mwb_wd : id_rD1;
        id_d.rd2      = wb_byp2 ? mwb_wd : id_rD2;
        id_d.imm      = id_imm;
        id_d.alu_op   = id_alu_op;
        id_d.alub_sel = id_alub_sel;
        id_d.rf_we    = id_rf_we;
        id_d.ram_we   = id_ram_we;
        id_d.is_load  = id_is_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ex_q <= BUBBLE;
        else if (flush || hazard)  ex_q <= BUBBLE;
        else                       ex_q <= id_d;
    end

    function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_e sel,
                                                 input logic [XLEN-1:0] held);
        case (sel)
            FWD_EXM: return exm_wd;
            FWD_MWB: return mwb_wd;
            default: return held;
        endcase
    endfunction

    assign ex_rD1      = fwd_mux(fwd1_sel, ex_q.rd1);
    assign ex_rD2      = fwd_mux(fwd2_sel, ex_q.rd2);
    assign ex_valid    = ex_q.valid;
    assign ex_alub_sel = ex_q.alub_sel;
    assign ex_rf_we    = ex_q.rf_we;
    assign ex_ram_we   = ex_q.ram_we;
    assign ex_is_load  = ex_q.is_load;
    assign ex_pc       = ex_q.pc;
    assign ex_imm      = ex_q.imm;
    assign ex_rd       = ex_q.rd;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_alu_op   = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: reset, a vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
// Expectations follow the build: ID_EX_FORWARD_EN defined or not.
module tb_id_ex_reg;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, id_valid;
    logic [31:0] id_pc, id_rD1, id_rD2, id_imm, exm_wd, mwb_wd;
    logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, mwb_rd;
    logic [3:0]  id_alu_op;
    logic        id_alub_sel, id_rf_we, id_ram_we, id_is_load;
    logic        exm_rf_we, exm_is_load, mwb_rf_we;
    logic        stall, ex_valid, ex_alub_sel, ex_rf_we, ex_ram_we, ex_is_load;
    logic [31:0] ex_pc, ex_imm, ex_rD1, ex_rD2;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [3:0]  ex_alu_op;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rD1(id_rD1), .id_rD2(id_rD2), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alub_sel(id_alub_sel),
        .id_rf_we(id_rf_we), .id_ram_we(id_ram_we), .id_is_load(id_is_load),
        .exm_rd(exm_rd), .exm_rf_we(exm_rf_we), .exm_is_load(exm_is_load),
        .exm_wd(exm_wd), .mwb_rd(mwb_rd), .mwb_rf_we(mwb_rf_we),
        .mwb_wd(mwb_wd), .stall(stall), .ex_valid(ex_valid),
        .ex_alub_sel(ex_alub_sel), .ex_rf_we(ex_rf_we),
        .ex_ram_we(ex_ram_we), .ex_is_load(ex_is_load), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_alu_op(ex_alu_op), .ex_rD1(ex_rD1), .ex_rD2(ex_rD2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        flush = 0; id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rD1 = 0; id_rD2 = 0; id_imm = 0; id_alu_op = 0; id_alub_sel = 0;
        id_rf_we = 0; id_ram_we = 0; id_is_load = 0;
        exm_rd = 0; exm_rf_we = 0; exm_is_load = 0; exm_wd = 0;
        mwb_rd = 0; mwb_rf_we = 0; mwb_wd = 0;
    endtask

    // ---------------- vector table (sources are x0: never a hazard) -------
    typedef struct {
        bit flush, valid;
        bit [31:0] pc;
        bit [4:0] rd;
        bit [3:0] op;
        bit rf_we, ram_we, is_load;
        bit [4:0] exm_rd;
        bit exm_we;
        bit [31:0] rd1;
        bit e_valid;
        bit [31:0] e_pc;
        bit [4:0] e_rd;
        bit [3:0] e_op;
        bit e_rf_we;
        bit [31:0] e_rd1;
    } vec_t;

    // ---------------- behavioural model of the EX-stage contents ----------
    typedef struct packed {
        bit valid;
        bit [31:0] pc;
        bit [4:0] rd, rs1, rs2;
        bit [31:0] rd1, rd2, imm;
        bit [3:0] op;
        bit alub, rf_we, ram_we, is_load;
    } mex_t;

    mex_t m, nx;

    function automatic bit hit(input bit we, input bit [4:0] rd, input bit [4:0] rs);
        return we && rd != 0 && rd == rs;
    endfunction

    function automatic bit model_hazard();
        bit ex_hit, down_hit;
        if (!id_valid) return 0;
        ex_hit = m.valid && (hit(m.rf_we, m.rd, id_rs1) || hit(m.rf_we, m.rd, id_rs2));
        down_hit = hit(exm_rf_we, exm_rd, id_rs1) || hit(exm_rf_we, exm_rd, id_rs2) ||
                   hit(mwb_rf_we, mwb_rd, id_rs1) || hit(mwb_rf_we, mwb_rd, id_rs2);
        if (FWD) return ex_hit && m.is_load;
        return ex_hit || down_hit;
    endfunction

    function automatic bit [31:0] model_op(input bit [4:0] rs, input bit [31:0] held);
        if (!FWD) return held;
        if (hit(exm_rf_we, exm_rd, rs) && !exm_is_load) return exm_wd;
        if (hit(mwb_rf_we, mwb_rd, rs)) return mwb_wd;
        return held;
    endfunction

    vec_t vecs[6];

    initial begin
        bit h;

        vecs[0] = '{0,1,32'h200,5, 4'h2,1,0,0, 0,0,32'hAAAA0001, 1,32'h200,5, 4'h2,1,32'hAAAA0001};
        vecs[1] = '{1,1,32'h204,6, 4'h6,1,0,0, 0,0,32'h12345678, 0,32'h0,  0, 4'h0,0,32'h0};
        vecs[2] = '{0,0,32'h208,7, 4'h5,0,0,0, 0,0,32'h5,        0,32'h208,7, 4'h5,0,32'h5};
        vecs[3] = '{0,1,32'h20C,8, 4'h2,1,0,1, 0,1,32'h1000,     1,32'h20C,8, 4'h2,1,32'h1000};
        vecs[4] = '{0,1,32'h210,0, 4'h2,0,1,0, 0,0,32'hDEAD,     1,32'h210,0, 4'h2,0,32'hDEAD};
        vecs[5] = '{0,1,32'hFFFFFFFC,31,4'hB,1,0,0,31,1,32'hFFFFFFFF,1,32'hFFFFFFFC,31,4'hB,1,32'hFFFFFFFF};

        // ---- reset held, then released ----
        set_idle();
        rst_n = 0; id_valid = 1; id_pc = 32'h100; id_rf_we = 1; id_alu_op = 4'h2;
        #12;
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_rf_we", 32'(ex_rf_we), 0);
        chk("rst_ram_we", 32'(ex_ram_we), 0);
        chk("rst_alu_op", 32'(ex_alu_op), 0);
        chk("rst_stall", 32'(stall), 0);
        #1 rst_n = 1;
        tick();
        chk("rel_pc", ex_pc, 32'h100);
        chk("rel_valid", 32'(ex_valid), 1);

        // ---- vector table ----
        for (int i = 0; i < 6; i++) begin
            set_idle();
            flush = vecs[i].flush; id_valid = vecs[i].valid; id_pc = vecs[i].pc;
            id_rd = vecs[i].rd; id_alu_op = vecs[i].op; id_rf_we = vecs[i].rf_we;
            id_ram_we = vecs[i].ram_we; id_is_load = vecs[i].is_load;
            exm_rd = vecs[i].exm_rd; exm_rf_we = vecs[i].exm_we; id_rD1 = vecs[i].rd1;
            #1 chk($sformatf("vec%0d_stall", i), 32'(stall), 0);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_pc", i), ex_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d_op", i), 32'(ex_alu_op), 32'(vecs[i].e_op));
            chk($sformatf("vec%0d_rf_we", i), 32'(ex_rf_we), 32'(vecs[i].e_rf_we));
            chk($sformatf("vec%0d_rD1", i), ex_rD1, vecs[i].e_rd1);
        end

        // ---- producer followed by dependent consumer ----
        set_idle();
        id_valid = 1; id_pc = 32'h300; id_rf_we = 1;
`ifdef ID_EX_FORWARD_EN
        id_rd = 6; id_is_load = 1;                 // lw x6
`else
        id_rd = 3;                                 // addi x3
`endif
        tick();
        set_idle();
        id_valid = 1; id_pc = 32'h304; id_rs1 = FWD ? 5'd6 : 5'd3; id_rd = 9; id_rf_we = 1;
        #1 chk("dep_stall_ex", 32'(stall), 1);
        tick();
        chk("dep_bubble", 32'(ex_valid), 0);
`ifdef ID_EX_FORWARD_EN
        mwb_rd = 6; mwb_rf_we = 1; mwb_wd = 32'hCAFE;
        #1 chk("lu_stall_once", 32'(stall), 0);
        tick();
        mwb_rf_we = 0; mwb_rd = 0; mwb_wd = 0;
        #1 chk("lu_rD1", ex_rD1, 32'hCAFE);
        chk("lu_valid", 32'(ex_valid), 1);
`else
        exm_rd = 3; exm_rf_we = 1; exm_wd = 32'h77;
        #1 chk("dep_stall_exm", 32'(stall), 1);
        tick();
        exm_rd = 0; exm_rf_we = 0; mwb_rd = 3; mwb_rf_we = 1; mwb_wd = 32'h77;
        #1 chk("dep_stall_mwb", 32'(stall), 1);
        tick();
        mwb_rd = 0; mwb_rf_we = 0; id_rD1 = 32'h77;
        #1 chk("dep_stall_done", 32'(stall), 0);
        tick();
        chk("dep_rD1", ex_rD1, 32'h77);
        chk("dep_pc", ex_pc, 32'h304);
`endif

        // ---- flush together with load-use hazard ----
        set_idle();
        id_valid = 1; id_pc = 32'h400; id_rd = 6; id_rf_we = 1; id_is_load = 1;
        tick();
        set_idle();
        id_valid = 1; id_pc = 32'h404; id_rs1 = 6; id_rd = 2; id_rf_we = 1; flush = 1;
        #1 chk("flush_haz_stall", 32'(stall), 0);
        tick();
        chk("flush_haz_valid", 32'(ex_valid), 0);
        chk("flush_haz_pc", ex_pc, 0);

`ifdef ID_EX_FORWARD_EN
        // ---- EX/MEM forward priority over MEM/WB; load never forwards ----
        set_idle();
        id_valid = 1; id_pc = 32'h500; id_rs1 = 5; id_rd = 1; id_rf_we = 1;
        tick();
        set_idle();
        exm_rd = 5; exm_rf_we = 1; exm_wd = 32'h1234;
        #1 chk("fwd_exm", ex_rD1, 32'h1234);
        mwb_rd = 5; mwb_rf_we = 1; mwb_wd = 32'h9;
        #1 chk("fwd_exm_prio", ex_rD1, 32'h1234);
        exm_is_load = 1;
        #1 chk("fwd_exm_load", ex_rD1, 32'h9);

        // ---- ID-side WB bypass, x0 never bypassed/forwarded ----
        set_idle();
        id_valid = 1; id_rs1 = 7; id_rD1 = 0; mwb_rd = 7; mwb_rf_we = 1; mwb_wd = 32'h55;
        tick();
        set_idle();
        #1 chk("wb_byp", ex_rD1, 32'h55);
        id_valid = 1; id_rs2 = 0; id_rD2 = 32'h11; mwb_rd = 0; mwb_rf_we = 1; mwb_wd = 32'h99;
        tick();
        exm_rd = 0; exm_rf_we = 1; exm_wd = 32'h77;
        #1 chk("x0_no_fwd", ex_rD2, 32'h11);
`endif

        // ---- reset mid-stream ----
        set_idle();
        id_valid = 1; id_pc = 32'h600; id_rf_we = 1; id_rd = 4;
        tick();
        rst_n = 0;
        #1 chk("midrst_valid", 32'(ex_valid), 0);
        chk("midrst_pc", ex_pc, 0);
        chk("midrst_rf_we", 32'(ex_rf_we), 0);
        #1 rst_n = 1;

        // ---- randomized run against the model ----
        m = '0;
        for (int n = 0; n < 400; n++) begin
            flush = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_pc = $urandom; id_imm = $urandom; id_rD1 = $urandom; id_rD2 = $urandom;
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3)); id_alu_op = 4'($urandom);
            id_alub_sel = 1'($urandom); id_rf_we = ($urandom_range(0, 3) != 0);
            id_ram_we = 1'($urandom); id_is_load = ($urandom_range(0, 2) == 0);
            exm_rd = 5'($urandom_range(0, 3)); exm_rf_we = 1'($urandom);
            exm_is_load = 1'($urandom); exm_wd = $urandom;
            mwb_rd = 5'($urandom_range(0, 3)); mwb_rf_we = 1'($urandom); mwb_wd = $urandom;
            #1;
            h = model_hazard();
            chk("rnd_stall", 32'(stall), 32'(h && !flush));
            chk("rnd_rD1", ex_rD1, model_op(m.rs1, m.rd1));
            chk("rnd_rD2", ex_rD2, model_op(m.rs2, m.rd2));
            nx = '0;
            if (!flush && !h) begin
                nx.valid = id_valid; nx.pc = id_pc; nx.rd = id_rd;
                nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.imm = id_imm; nx.op = id_alu_op;
                nx.alub = id_alub_sel; nx.rf_we = id_rf_we; nx.ram_we = id_ram_we;
                nx.is_load = id_is_load;
                nx.rd1 = (FWD && hit(mwb_rf_we, mwb_rd, id_rs1)) ? mwb_wd : id_rD1;
                nx.rd2 = (FWD && hit(mwb_rf_we, mwb_rd, id_rs2)) ? mwb_wd : id_rD2;
            end
            tick();
            m = nx;
            chk("rnd_valid", 32'(ex_valid), 32'(m.valid));
            chk("rnd_pc", ex_pc, m.pc);
            chk("rnd_imm", ex_imm, m.imm);
            chk("rnd_ctl", {24'b0, ex_alu_op, ex_alub_sel, ex_rf_we, ex_ram_we, ex_is_load},
                {24'b0, m.op, m.alub, m.rf_we, m.ram_we, m.is_load});
            chk("rnd_regs", {17'b0, ex_rd, ex_rs1, ex_rs2}, {17'b0, m.rd, m.rs1, m.rs2});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
